// File: rtl/accel_bus_if.sv
// accel_bus_if: buffered bridge between the CPU accelerator-bus port and the
// neural-network accelerator. A command FIFO carries CPU writes to the
// accelerator over valid/ready; a result FIFO returns accelerator results
// as CPU read data.
// Optional build macro: ACCEL_BUS_LOOPBACK_EN adds a `loopback` input that
// routes command heads straight into the result FIFO.
module accel_bus_if #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_wr_en,
   input  logic [15:0]   cpu_wr_data,
   input  logic          cpu_rd_en,
   output logic [15:0]   cpu_rd_data,
   output logic          cpu_stall,
   output logic          acc_cmd_valid,
   output logic [15:0]   acc_cmd_data,
   input  logic          acc_cmd_ready,
   input  logic          acc_res_valid,
   input  logic [15:0]   acc_res_data,
   output logic          acc_res_ready,
   output logic [CW-1:0] cmd_count,
   output logic [CW-1:0] res_count,
   input  logic          clr_err,
   output logic          err_ovf,
`ifdef ACCEL_BUS_LOOPBACK_EN
   output logic          err_udf,
   input  logic          loopback
`else
   output logic          err_udf
`endif
);

   localparam int unsigned PW = CW - 1;
   localparam int unsigned DW = 16;

   logic [DW-1:0] cmd_mem [DEPTH];
   logic [PW-1:0] cmd_wr_ptr;
   logic [PW-1:0] cmd_rd_ptr;
   logic [CW-1:0] cmd_cnt;

   logic [DW-1:0] res_mem [DEPTH];
   logic [PW-1:0] res_wr_ptr;
   logic [PW-1:0] res_rd_ptr;
   logic [CW-1:0] res_cnt;

   logic          cmd_full;
   logic          cmd_empty;
   logic          res_full;
   logic          res_empty;
   logic          cmd_push;
   logic          cmd_pop;
   logic          res_push;
   logic          res_pop;
   logic [DW-1:0] res_wdata;

   // Occupancy flags, sampled from the registered counts only
   assign cmd_full  = (cmd_cnt == CW'(DEPTH));
   assign cmd_empty = (cmd_cnt == '0);
   assign res_full  = (res_cnt == CW'(DEPTH));
   assign res_empty = (res_cnt == '0);

   // CPU side: a write into a full FIFO is dropped, a read from an empty one ignored
   assign cmd_push  = cpu_wr_en & ~cmd_full;
   assign res_pop   = cpu_rd_en & ~res_empty;
   assign cpu_stall = (cpu_wr_en & cmd_full) | (cpu_rd_en & res_empty);

   // Heads are read straight out of the storage registers
   assign acc_cmd_data = cmd_mem[cmd_rd_ptr];
   assign cpu_rd_data  = res_empty ? '0 : res_mem[res_rd_ptr];

`ifdef ACCEL_BUS_LOOPBACK_EN
   logic lb_xfer;

   // Loopback moves the command head into the result FIFO and hides the accelerator
   assign lb_xfer       = loopback & ~cmd_empty & ~res_full;
   assign acc_cmd_valid = ~cmd_empty & ~loopback;
   assign acc_res_ready = ~res_full & ~loopback;
   assign cmd_pop       = loopback ? lb_xfer : (~cmd_empty & acc_cmd_ready);
   assign res_push      = loopback ? lb_xfer : (acc_res_valid & ~res_full);
   assign res_wdata     = loopback ? acc_cmd_data : acc_res_data;
`else
   // Accelerator handshakes
   assign acc_cmd_valid = ~cmd_empty;
   assign acc_res_ready = ~res_full;
   assign cmd_pop       = ~cmd_empty & acc_cmd_ready;
   assign res_push      = acc_res_valid & ~res_full;
   assign res_wdata     = acc_res_data;
`endif

   assign cmd_count = cmd_cnt;
   assign res_count = res_cnt;

   // Command FIFO storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_mem    <= '{default: '0};
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_cnt    <= '0;
      end else begin
         if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= cpu_wr_data;
            cmd_wr_ptr          <= cmd_wr_ptr + PW'(1);
         end
         if (cmd_pop) begin
            cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
         end
         case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt <= cmd_cnt + CW'(1);
            2'b01:   cmd_cnt <= cmd_cnt - CW'(1);
            default: cmd_cnt <= cmd_cnt;
         endcase
      end
   end

   // Result FIFO storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_mem    <= '{default: '0};
         res_wr_ptr <= '0;
         res_rd_ptr <= '0;
         res_cnt    <= '0;
      end else begin
         if (res_push) begin
            res_mem[res_wr_ptr] <= res_wdata;
            res_wr_ptr          <= res_wr_ptr + PW'(1);
         end
         if (res_pop) begin
            res_rd_ptr <= res_rd_ptr + PW'(1);
         end
         case ({res_push, res_pop})
            2'b10:   res_cnt <= res_cnt + CW'(1);
            2'b01:   res_cnt <= res_cnt - CW'(1);
            default: res_cnt <= res_cnt;
         endcase
      end
   end

   // Sticky error flags; a new error event wins over a clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (cpu_wr_en & cmd_full) begin
            err_ovf <= 1'b1;
         end else if (clr_err) begin
            err_ovf <= 1'b0;
         end
         if (cpu_rd_en & res_empty) begin
            err_udf <= 1'b1;
         end else if (clr_err) begin
            err_udf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_accel_bus_if.sv
// Testbench for accel_bus_if: queue-based reference model plus a scoreboard
// monitor that checks every word leaving either FIFO.
module tb_accel_bus_if;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_wr_en = 1'b0;
   logic [15:0]   cpu_wr_data = '0;
   logic          cpu_rd_en = 1'b0;
   logic [15:0]   cpu_rd_data;
   logic          cpu_stall;
   logic          acc_cmd_valid;
   logic [15:0]   acc_cmd_data;
   logic          acc_cmd_ready = 1'b0;
   logic          acc_res_valid = 1'b0;
   logic [15:0]   acc_res_data = '0;
   logic          acc_res_ready;
   logic [CW-1:0] cmd_count;
   logic [CW-1:0] res_count;
   logic          clr_err = 1'b0;
   logic          err_ovf;
   logic          err_udf;
   logic          lb = 1'b0;

   int n_tests = 0;
   int n_fail = 0;
   int n_cmd_seen = 0;

   // Reference model: FIFO contents as plain queues plus sticky flags
   logic [15:0] m_cmd[$];
   logic [15:0] m_res[$];
   logic        m_ovf;
   logic        m_udf;
   // Scoreboard: words expected to leave each FIFO, in order
   logic [15:0] exp_cmd[$];
   logic [15:0] exp_res[$];

   accel_bus_if #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
      .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
      .acc_cmd_valid(acc_cmd_valid), .acc_cmd_data(acc_cmd_data), .acc_cmd_ready(acc_cmd_ready),
      .acc_res_valid(acc_res_valid), .acc_res_data(acc_res_data), .acc_res_ready(acc_res_ready),
      .cmd_count(cmd_count), .res_count(res_count),
      .clr_err(clr_err), .err_ovf(err_ovf),
`ifdef ACCEL_BUS_LOOPBACK_EN
      .err_udf(err_udf), .loopback(lb)
`else
      .err_udf(err_udf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compares each word as it is handed over
   always @(negedge clk) begin : monitor
      logic [15:0] e;
      if (!rst) begin
         if (acc_cmd_valid && acc_cmd_ready) begin
            if (exp_cmd.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL cmd_sb: got %h but no command expected", acc_cmd_data);
            end else begin
               e = exp_cmd.pop_front();
               check("cmd_sb", 32'(acc_cmd_data), 32'(e));
               n_cmd_seen++;
            end
         end
         if (cpu_rd_en && res_count != '0) begin
            if (exp_res.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL res_sb: got %h but no result expected", cpu_rd_data);
            end else begin
               e = exp_res.pop_front();
               check("res_sb", 32'(cpu_rd_data), 32'(e));
            end
         end
      end
   end

   // Asynchronous reset: outputs must take reset values without a clock edge
   task automatic reset_dut();
      cpu_wr_en = 0; cpu_rd_en = 0; acc_cmd_ready = 0; acc_res_valid = 0; clr_err = 0;
      rst = 1'b1;
      #1;
      check("rst_cmd_valid", 32'(acc_cmd_valid), 32'd0);
      check("rst_cmd_data",  32'(acc_cmd_data),  32'd0);
      check("rst_res_ready", 32'(acc_res_ready), 32'd1);
      check("rst_rd_data",   32'(cpu_rd_data),   32'd0);
      check("rst_stall",     32'(cpu_stall),     32'd0);
      check("rst_cmd_count", 32'(cmd_count),     32'd0);
      check("rst_res_count", 32'(res_count),     32'd0);
      check("rst_err_ovf",   32'(err_ovf),       32'd0);
      check("rst_err_udf",   32'(err_udf),       32'd0);
      m_cmd.delete(); m_res.delete(); exp_cmd.delete(); exp_res.delete();
      m_ovf = 0; m_udf = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One clock: drive inputs, check model-predicted state mid-cycle, advance model
   task automatic cycle(input logic wr, input logic [15:0] wd, input logic rd,
                        input logic crdy, input logic rv, input logic [15:0] rdat,
                        input logic clr);
      int nc;
      int nr;
      bit c_pop;
      bit r_push;
      bit r_pop;
      logic [15:0] r_word;
      cpu_wr_en = wr; cpu_wr_data = wd; cpu_rd_en = rd;
      acc_cmd_ready = crdy; acc_res_valid = rv; acc_res_data = rdat; clr_err = clr;
      @(negedge clk);
      nc = m_cmd.size();
      nr = m_res.size();
      check("cmd_count", 32'(cmd_count), 32'(nc));
      check("res_count", 32'(res_count), 32'(nr));
      check("acc_cmd_valid", 32'(acc_cmd_valid), 32'(nc != 0 && !lb));
      check("acc_res_ready", 32'(acc_res_ready), 32'(nr != DEPTH && !lb));
      check("cpu_stall", 32'(cpu_stall), 32'((wr && nc == DEPTH) || (rd && nr == 0)));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      check("err_udf", 32'(err_udf), 32'(m_udf));
      if (nr == 0) check("rd_data_empty", 32'(cpu_rd_data), 32'd0);
      if (nc != 0) check("cmd_head", 32'(acc_cmd_data), 32'(m_cmd[0]));
      r_word = rdat;
      if (lb) begin
         c_pop  = (nc > 0) && (nr < DEPTH);
         r_push = c_pop;
         if (c_pop) r_word = m_cmd[0];
      end else begin
         c_pop  = (nc > 0) && crdy;
         r_push = rv && (nr < DEPTH);
      end
      r_pop = rd && (nr > 0);
      if (c_pop) begin
         void'(m_cmd.pop_front());
         if (lb) void'(exp_cmd.pop_front());
      end
      if (wr && nc < DEPTH) begin
         m_cmd.push_back(wd);
         exp_cmd.push_back(wd);
      end
      if (r_pop) void'(m_res.pop_front());
      if (r_push) begin
         m_res.push_back(r_word);
         exp_res.push_back(r_word);
      end
      if (wr && nc == DEPTH) m_ovf = 1; else if (clr) m_ovf = 0;
      if (rd && nr == 0)     m_udf = 1; else if (clr) m_udf = 0;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, 0);
   endtask

   initial begin
      int base;
      int sent;
      reset_dut();

      // Two queued commands, then drained by the accelerator
      cycle(1, 16'h1234, 0, 0, 0, '0, 0);
      cycle(1, 16'h5678, 0, 0, 0, '0, 0);
      check("t1_count", 32'(cmd_count), 32'd2);
      check("t1_head", 32'(acc_cmd_data), 32'h1234);
      base = n_cmd_seen;
      cycle(0, '0, 0, 1, 0, '0, 0);
      cycle(0, '0, 0, 1, 0, '0, 0);
      check("t1_valid", 32'(acc_cmd_valid), 32'd0);
      check("t1_drained", 32'(cmd_count), 32'd0);
      check("t1_seen", 32'(n_cmd_seen - base), 32'd2);

      // Overflow: fifth write dropped and flagged, then cleared
      for (int i = 0; i < 4; i++) cycle(1, 16'h0A00 + 16'(i), 0, 0, 0, '0, 0);
      cycle(1, 16'hDEAD, 0, 0, 0, '0, 0);
      check("t2_ovf", 32'(err_ovf), 32'd1);
      check("t2_count", 32'(cmd_count), 32'd4);
      cycle(0, '0, 0, 0, 0, '0, 1);
      check("t2_clr", 32'(err_ovf), 32'd0);
      for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1, 0, '0, 0);

      // Result FIFO fill, drain, underflow
      for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0, 1, 16'hAAAA + 16'(i), 0);
      check("t3_ready", 32'(acc_res_ready), 32'd0);
      check("t3_count", 32'(res_count), 32'd4);
      check("t3_head", 32'(cpu_rd_data), 32'hAAAA);
      for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0, '0, 0);
      check("t3_empty_data", 32'(cpu_rd_data), 32'd0);
      cycle(0, '0, 1, 0, 0, '0, 0);
      check("t3_udf", 32'(err_udf), 32'd1);
      cycle(0, '0, 0, 0, 0, '0, 1);

      // Simultaneous push/pop with one entry, then with a full FIFO
      cycle(0, '0, 0, 0, 1, 16'h0001, 0);
      cycle(0, '0, 1, 0, 1, 16'h0002, 0);
      check("t4_count", 32'(res_count), 32'd1);
      check("t4_head", 32'(cpu_rd_data), 32'h0002);
      for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1, 16'h0003 + 16'(i), 0);
      cycle(0, '0, 1, 0, 1, 16'h0006, 0);
      check("t4_full_pop", 32'(res_count), 32'd3);
      check("t4_full_head", 32'(cpu_rd_data), 32'h0003);
      for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0, '0, 0);

      // Pointer wrap: ten words with ready toggling
      base = n_cmd_seen;
      sent = 0;
      for (int i = 0; i < 30; i++) begin
         if (sent < 10 && m_cmd.size() < DEPTH) begin
            cycle(1, 16'h0100 + 16'(sent), 0, 1'(i % 2), 0, '0, 0);
            sent++;
         end else begin
            cycle(0, '0, 0, 1'(i % 2), 0, '0, 0);
         end
      end
      check("t5_seen", 32'(n_cmd_seen - base), 32'd10);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
               1'($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < 6; i++) cycle(0, '0, 1, 1, 0, '0, 1);

      // Reset with commands in flight
      for (int i = 0; i < 3; i++) cycle(1, 16'h0C00 + 16'(i), 0, 0, 0, '0, 0);
      reset_dut();
      cycle(1, 16'h0F0F, 0, 0, 0, '0, 0);
      check("t6_head", 32'(acc_cmd_data), 32'h0F0F);
      check("t6_count", 32'(cmd_count), 32'd1);
      cycle(0, '0, 0, 1, 0, '0, 0);

`ifdef ACCEL_BUS_LOOPBACK_EN
      // Loopback: command head reappears as read data one cycle later
      lb = 1'b1;
      cycle(1, 16'h00FF, 0, 0, 0, '0, 0);
      check("t7_valid", 32'(acc_cmd_valid), 32'd0);
      check("t7_cmd_head", 32'(acc_cmd_data), 32'h00FF);
      idle(1);
      check("t7_rd_data", 32'(cpu_rd_data), 32'h00FF);
      check("t7_cmd_count", 32'(cmd_count), 32'd0);
      cycle(0, '0, 1, 0, 0, '0, 0);
      lb = 1'b0;
`endif

      idle(2);
      check("end_cmd_sb", 32'(exp_cmd.size()), 32'd0);
      check("end_res_sb", 32'(exp_res.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
